as_gpio_ctrl: RTL and testbench
===============================

Name: as_gpio_ctrl

Overview:
Memory-mapped GPIO peripheral inside as_top_mem, between the core's data-memory bus and the bidirectional gpio_io pads. It holds direction and output registers, synchronises pad inputs, detects input edges into a sticky status register, and raises an interrupt. It pulses cs_o for one cycle after every write to the output register, so the integration bench samples the pads only when they are stable.

Parameters:
NR_GPIOS, 8, number of pads (1..64)
GPIO_ID, 64'h81, constant returned by the ID register
ADDR_WIDTH, 3, word-address width (register select)
DB_CYCLES, 16, debounce stability count (only with GPIO_DEBOUNCE_EN; 2..65535)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
req_i  in  1  bus request, held until ack_o
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_WIDTH  register word address
wdata_i  in  64  write data
rdata_o  out  64  read data, valid while ack_o = 1
ack_o  out  1  one-cycle access completion
gpio_io  inout  NR_GPIOS  pads; bit driven when DIR bit = 1, else Z
cs_o  out  1  one-cycle strobe after an OUT write
irq_o  out  1  level interrupt = |(EDGE & IRQEN)

Behaviour:
- Reset (rst_i = 1 at posedge clk_i): DIR = 0 (all pads Z), OUT = 0, EDGE = 0, IRQEN = 0, both synchroniser stages = 0, rdata_o = 0, ack_o = 0, cs_o = 0, irq_o = 0, FSM = IDLE. Reset mid-access drops the access; ack_o is never issued for it.
- Register map (word address): 0 ID (RO, GPIO_ID); 1 DIR (RW); 2 OUT (RW); 3 IN (RO, synchronised pad values); 4 EDGE (W1C); 5 IRQEN (RW); 6..7 read 0, writes ignored.
- Only bits [NR_GPIOS-1:0] are stored. Read data is zero-extended to 64 bits. Upper write bits are ignored.
- Bus FSM states:
  - IDLE: on req_i go to ACK and latch the access.
  - ACK: ack_o = 1 for exactly one cycle; write takes effect at this edge; rdata_o is valid; go to WAIT.
  - WAIT: return to IDLE when req_i = 0. Back-to-back accesses need req_i to drop for at least one cycle.
- Read latency: ack_o asserts 1 cycle after req_i is first sampled high. rdata_o returns to 0 when ack_o = 0.
- cs_o: asserts in the cycle after the OUT write's ack cycle, for exactly 1 cycle, so pads are already updated. No pulse for writes to other registers.
- Pads: gpio_io[i] = DIR[i] ? OUT[i] : Z. Inputs pass through a 2-flop synchroniser; IN reads stage 2, so pad-to-IN latency is 2 cycles. Output pads read back their own driven value.
- Edge detect: a change between stage 2 and its previous value sets EDGE[i]; both rise and fall count.
- Simultaneous events:
  - W1C clear and new edge on the same bit in the same cycle: set wins.
  - EDGE is updated every cycle, independent of bus activity.
- irq_o is registered: 1 cycle after EDGE or IRQEN changes.
- A DIR change from output to input produces an edge only if the sampled value changes.

Optional Feature:
GPIO_DEBOUNCE_EN: when defined, each input adds a per-bit counter after the synchroniser. The debounced value updates only after stage 2 differs from it for DB_CYCLES consecutive cycles; the counter restarts on any reversal. IN and edge detection use the debounced value, so latency is 2 + DB_CYCLES. Reset clears counters and debounced values to 0. When undefined: no counters, latency 2, no DB_CYCLES logic synthesised.

Test Plan:
- Reset, read addr 0 → ack_o 1 cycle after req_i, rdata_o = 64'h81; all pads Z, cs_o = 0, irq_o = 0.
- Write DIR = 8'h7F, OUT = 8'h01, external drive gpio_io[7] = 1 → cs_o pulses once, the cycle after the OUT ack; gpio_io = 8'h81 at that edge; read IN = 8'h81.
- DIR = 0, IRQEN = 8'h08, toggle pad 3 0→1 → EDGE = 8'h08 two cycles after the pad change (no debounce); irq_o = 1 one cycle later; write EDGE 8'h08 → irq_o drops.
- W1C on bit 3 in the same cycle as a new pad-3 edge → EDGE[3] stays 1.
- Assert rst_i during the ACK state of a write to OUT → no cs_o pulse, OUT = 0, ack_o = 0 after reset.
- GPIO_DEBOUNCE_EN, DB_CYCLES = 4: a 3-cycle glitch on pad 0 → IN[0] unchanged, EDGE = 0; a 6-cycle high → IN[0] = 1 at cycle 2 + 4 after the rise.

Source files
------------

// File: rtl/as_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// as_gpio_ctrl
//   Memory-mapped GPIO peripheral. Holds per-pad direction and output
//   registers, synchronises pad inputs through two flops, records input
//   edges in a sticky write-one-to-clear status register, and raises a
//   registered level interrupt from the enabled edge bits. A one-cycle
//   cs_o strobe follows every write to the output register, once the pads
//   already show the new value.
//
//   Register map (word address):
//     0 ID    RO   GPIO_ID
//     1 DIR   RW   1 = pad driven from OUT
//     2 OUT   RW
//     3 IN    RO   synchronised (optionally debounced) pad values
//     4 EDGE  W1C  sticky input change flags
//     5 IRQEN RW
//     6..7    read 0, writes ignored
//
//   Ports:
//     clk_i    system clock
//     rst_i    synchronous active-high reset
//     req_i    bus request, held until ack_o
//     we_i     1 = write, 0 = read
//     addr_i   register word address
//     wdata_i  write data (bits above NR_GPIOS ignored)
//     rdata_o  read data, zero-extended, non-zero only while ack_o = 1
//     ack_o    one-cycle access completion
//     gpio_io  pads, bit driven when DIR bit = 1, else high impedance
//     cs_o     one-cycle strobe in the cycle after an OUT write's ack
//     irq_o    registered |(EDGE & IRQEN)
//
//   Optional build macro GPIO_DEBOUNCE_EN: adds a per-pad stability counter
//   after the synchroniser; IN and edge detection then use the debounced
//   value, which follows stage 2 only after DB_CYCLES consecutive cycles of
//   disagreement.
// ---------------------------------------------------------------------------
module as_gpio_ctrl #(
  parameter int unsigned NR_GPIOS   = 8,
  parameter logic [63:0] GPIO_ID    = 64'h81,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DB_CYCLES  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [63:0]           wdata_i,
  output logic [63:0]           rdata_o,
  output logic                  ack_o,
  inout  wire  [NR_GPIOS-1:0]   gpio_io,
  output logic                  cs_o,
  output logic                  irq_o
);

  if (NR_GPIOS < 1 || NR_GPIOS > 64 || DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_param_check
    $error("as_gpio_ctrl: parameter out of range");
  end

  localparam logic [ADDR_WIDTH-1:0] A_ID    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_DIR   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_OUT   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_IN    = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_EDGE  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_IRQEN = ADDR_WIDTH'(5);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_ack;
  logic                  w_capture;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [NR_GPIOS-1:0]   r_wdata;

  logic [NR_GPIOS-1:0]   r_dir;
  logic [NR_GPIOS-1:0]   r_out;
  logic [NR_GPIOS-1:0]   r_edge;
  logic [NR_GPIOS-1:0]   r_irqen;
  logic [NR_GPIOS-1:0]   r_sync1;
  logic [NR_GPIOS-1:0]   r_sync2;
  logic                  r_cs;
  logic                  r_irq;

  logic                  w_wr;
  logic                  w_wr_dir;
  logic                  w_wr_out;
  logic                  w_wr_edge;
  logic                  w_wr_irqen;
  logic [NR_GPIOS-1:0]   w_w1c;
  logic [NR_GPIOS-1:0]   w_in_cur;
  logic [NR_GPIOS-1:0]   w_in_nxt;
  logic [NR_GPIOS-1:0]   w_evt;
  logic [63:0]           w_rd;
  logic                  w_unused_wdata;

  // Only the low NR_GPIOS write bits are stored.
  if (NR_GPIOS < 64) begin : g_wdata_hi
    assign w_unused_wdata = ^wdata_i[63:NR_GPIOS];
  end else begin : g_wdata_full
    assign w_unused_wdata = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Bus FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_state_nxt = S_ACK;
          w_capture   = 1'b1;
        end
      end
      S_ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!req_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i[NR_GPIOS-1:0];
    end
  end

  assign w_wr       = w_ack && r_we;
  assign w_wr_dir   = w_wr && (r_addr == A_DIR);
  assign w_wr_out   = w_wr && (r_addr == A_OUT);
  assign w_wr_edge  = w_wr && (r_addr == A_EDGE);
  assign w_wr_irqen = w_wr && (r_addr == A_IRQEN);
  assign w_w1c      = w_wr_edge ? r_wdata : '0;

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dir   <= '0;
      r_out   <= '0;
      r_irqen <= '0;
    end else begin
      if (w_wr_dir) begin
        r_dir <= r_wdata;
      end
      if (w_wr_out) begin
        r_out <= r_wdata;
      end
      if (w_wr_irqen) begin
        r_irqen <= r_wdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pads and input path
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NR_GPIOS; g++) begin : g_pad
    assign gpio_io[g] = r_dir[g] ? r_out[g] : 1'bz;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_io;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned DB_CW = $clog2(DB_CYCLES);

  logic [NR_GPIOS-1:0] r_db;
  logic [DB_CW-1:0]    r_db_cnt     [NR_GPIOS];
  logic [DB_CW-1:0]    w_db_cnt_nxt [NR_GPIOS];

  // The counter holds the number of consecutive disagreeing cycles already
  // seen; the DB_CYCLES-th disagreement copies stage 2 into the debounced
  // value. Agreement (any reversal) restarts the count.
  always_comb begin
    w_in_nxt = r_db;
    for (int unsigned i = 0; i < NR_GPIOS; i++) begin
      w_db_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_db[i]) begin
        if (r_db_cnt[i] == DB_CW'(DB_CYCLES - 1)) begin
          w_in_nxt[i] = r_sync2[i];
        end else begin
          w_db_cnt_nxt[i] = r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_db <= '0;
      for (int unsigned i = 0; i < NR_GPIOS; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_db <= w_in_nxt;
      for (int unsigned i = 0; i < NR_GPIOS; i++) begin
        r_db_cnt[i] <= w_db_cnt_nxt[i];
      end
    end
  end

  assign w_in_cur = r_db;
`else
  // Stage 1 is the value stage 2 takes at the next edge, so comparing them
  // flags the change in the same cycle that IN updates.
  assign w_in_cur = r_sync2;
  assign w_in_nxt = r_sync1;
`endif

  assign w_evt = w_in_nxt ^ w_in_cur;

  // -------------------------------------------------------------------------
  // Edge status, interrupt and OUT-write strobe
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_edge <= '0;
      r_irq  <= 1'b0;
      r_cs   <= 1'b0;
    end else begin
      // A new edge on a bit being cleared in the same cycle keeps it set.
      r_edge <= (r_edge & ~w_w1c) | w_evt;
      r_irq  <= |(r_edge & r_irqen);
      r_cs   <= w_wr_out;
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  always_comb begin
    w_rd = '0;
    case (r_addr)
      A_ID:    w_rd = GPIO_ID;
      A_DIR:   w_rd = 64'(r_dir);
      A_OUT:   w_rd = 64'(r_out);
      A_IN:    w_rd = 64'(w_in_cur);
      A_EDGE:  w_rd = 64'(r_edge);
      A_IRQEN: w_rd = 64'(r_irqen);
      default: w_rd = '0;
    endcase
  end

  assign rdata_o = w_ack ? w_rd : '0;
  assign ack_o   = w_ack;
  assign cs_o    = r_cs;
  assign irq_o   = r_irq;

endmodule

// File: tb/tb_as_gpio_ctrl.sv
module tb_as_gpio_ctrl;

  localparam int          N  = 8;
  localparam int          AW = 3;
  localparam logic [63:0] ID = 64'h81;
`ifdef GPIO_DEBOUNCE_EN
  localparam int          DB = 4;
`else
  localparam int          DB = 16;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [63:0]   wdata;
  logic [63:0]   rdata;
  logic          ack;
  logic          cs;
  logic          irq;
  wire  [N-1:0]  gpio;

  logic [N-1:0]  ext_drv;

  // Reference model state
  logic [N-1:0]  m_dir, m_out, m_edge, m_irqen;
  logic          m_irq, m_cs;
  logic [N-1:0]  hist [3];   // pad samples: [0] newest edge, [1] one before, [2] two before
`ifdef GPIO_DEBOUNCE_EN
  logic [N-1:0]  m_db;
  int            m_run [N];
`endif

  logic          pw_valid;
  logic [AW-1:0] pw_addr;
  logic [63:0]   pw_data;

  int            n_vec = 0;
  int            n_err = 0;
  int            cs_pulses;
  logic [N-1:0]  pad_at_cs;
  logic [63:0]   rd;

  typedef struct {
    logic        w;
    int          a;
    logic [63:0] d;
    logic        chk;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [19];

  always #5 clk = ~clk;

  // External pad drivers: the bench drives every pad the model says is an input.
  for (genvar g = 0; g < N; g++) begin : g_ext
    assign gpio[g] = m_dir[g] ? 1'bz : ext_drv[g];
  end

  as_gpio_ctrl #(
    .NR_GPIOS  (N),
    .GPIO_ID   (ID),
    .ADDR_WIDTH(AW),
    .DB_CYCLES (DB)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .ack_o  (ack),
    .gpio_io(gpio),
    .cs_o   (cs),
    .irq_o  (irq)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_in();
`ifdef GPIO_DEBOUNCE_EN
    return m_db;
`else
    return hist[1];
`endif
  endfunction

  function automatic logic [63:0] model_read(input int a);
    case (a)
      0:       return ID;
      1:       return 64'(m_dir);
      2:       return 64'(m_out);
      3:       return 64'(m_in());
      4:       return 64'(m_edge);
      5:       return 64'(m_irqen);
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [N-1:0] pad_model();
    return (m_dir & m_out) | (~m_dir & ext_drv);
  endfunction

  // One clock: advance the model across the edge, then check the DUT 1 ns later.
  task automatic step();
    logic [N-1:0] pad, oldin, newin, clr;
    logic         irq_n, cs_n;
    @(posedge clk);
    if (rst) begin
      m_dir = '0; m_out = '0; m_edge = '0; m_irqen = '0;
      m_irq = 1'b0; m_cs = 1'b0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
`ifdef GPIO_DEBOUNCE_EN
      m_db = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
`endif
    end else begin
      pad   = pad_model();
      irq_n = |(m_edge & m_irqen);
      cs_n  = pw_valid && (pw_addr == 3'd2);
      oldin = m_in();
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = pad;
`ifdef GPIO_DEBOUNCE_EN
      for (int i = 0; i < N; i++) begin
        if (hist[2][i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_db[i]  = hist[2][i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
`endif
      newin = m_in();
      clr   = '0;
      if (pw_valid) begin
        case (pw_addr)
          3'd1:    m_dir   = pw_data[N-1:0];
          3'd2:    m_out   = pw_data[N-1:0];
          3'd4:    clr     = pw_data[N-1:0];
          3'd5:    m_irqen = pw_data[N-1:0];
          default: ;
        endcase
      end
      m_edge = (m_edge & ~clr) | (oldin ^ newin);
      m_irq  = irq_n;
      m_cs   = cs_n;
    end
    pw_valid = 1'b0;
    #1;
    chk("irq_o", 64'(irq), 64'(m_irq));
    chk("cs_o", 64'(cs), 64'(m_cs));
    chk("pads", 64'(gpio), 64'(pad_model()));
    if (cs) begin
      cs_pulses++;
      pad_at_cs = gpio;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Single access: ack one cycle after the request, write takes effect at
  // the edge closing the ack cycle, then idle long enough to re-arm.
  task automatic bus(input logic w, input int a, input logic [63:0] d, output logic [63:0] r);
    logic [63:0] exp_rd;
    req = 1'b1; we = w; addr = AW'(a); wdata = d;
    step();
    chk("ack_latency", 64'(ack), 64'd1);
    exp_rd = model_read(a);
    r = rdata;
    if (!w) chk("rdata", rdata, exp_rd);
    req = 1'b0;
    pw_valid = w; pw_addr = AW'(a); pw_data = d;
    step();
    chk("ack_one_cycle", 64'(ack), 64'd0);
    chk("rdata_idle", rdata, 64'd0);
    step();
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    ext_drv = '0; pw_valid = 1'b0; pw_addr = '0; pw_data = '0;
    m_dir = '0; m_out = '0; m_edge = '0; m_irqen = '0; m_irq = 1'b0; m_cs = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
    cs_pulses = 0; pad_at_cs = '0;

    tbl[0]  = '{1'b1, 4, 64'hFF,                  1'b0, 64'h0};
    tbl[1]  = '{1'b0, 0, 64'h0,                   1'b1, 64'h81};
    tbl[2]  = '{1'b1, 1, 64'hFFFF_FFFF_FFFF_FF0F, 1'b0, 64'h0};
    tbl[3]  = '{1'b0, 1, 64'h0,                   1'b1, 64'h0F};
    tbl[4]  = '{1'b1, 2, 64'hA5,                  1'b0, 64'h0};
    tbl[5]  = '{1'b0, 2, 64'h0,                   1'b1, 64'hA5};
    tbl[6]  = '{1'b0, 3, 64'h0,                   1'b1, 64'h05};
    tbl[7]  = '{1'b1, 5, 64'h3C,                  1'b0, 64'h0};
    tbl[8]  = '{1'b0, 5, 64'h0,                   1'b1, 64'h3C};
    tbl[9]  = '{1'b1, 6, 64'hFF,                  1'b0, 64'h0};
    tbl[10] = '{1'b0, 6, 64'h0,                   1'b1, 64'h0};
    tbl[11] = '{1'b0, 7, 64'h0,                   1'b1, 64'h0};
    tbl[12] = '{1'b1, 0, 64'h12,                  1'b0, 64'h0};
    tbl[13] = '{1'b0, 0, 64'h0,                   1'b1, 64'h81};
    tbl[14] = '{1'b0, 4, 64'h0,                   1'b1, 64'h05};
    tbl[15] = '{1'b1, 4, 64'h01,                  1'b0, 64'h0};
    tbl[16] = '{1'b0, 4, 64'h0,                   1'b1, 64'h04};
    tbl[17] = '{1'b1, 4, 64'hFF,                  1'b0, 64'h0};
    tbl[18] = '{1'b0, 4, 64'h0,                   1'b1, 64'h00};

    // Reset state
    steps(2);
    rst = 1'b0;
    #0;
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    bus(1'b0, 0, 64'h0, rd);
    chk("id_read", rd, 64'h81);
    // All pads high impedance: external pattern appears unaltered
    ext_drv = 8'h5A;
    steps(2);
    chk("pads_hiz", 64'(gpio), 64'h5A);
    ext_drv = 8'h00;
    steps(4);

    // Register map table
    for (int i = 0; i < 19; i++) begin
      bus(tbl[i].w, tbl[i].a, tbl[i].d, rd);
      if (tbl[i].chk) chk($sformatf("table_%0d", i), rd, tbl[i].exp);
    end

    // Output drive, read-back, cs_o timing
    bus(1'b1, 2, 64'h0, rd);
    bus(1'b1, 1, 64'h7F, rd);
    ext_drv = 8'h80;
    cs_pulses = 0;
    bus(1'b1, 2, 64'h01, rd);
    chk("cs_pulse_count", 64'(cs_pulses), 64'd1);
    chk("pads_at_cs", 64'(pad_at_cs), 64'h81);
    bus(1'b0, 3, 64'h0, rd);
    chk("in_readback", rd, 64'h81);
    cs_pulses = 0;
    bus(1'b1, 5, 64'h0, rd);
    chk("no_cs_other_reg", 64'(cs_pulses), 64'd0);

    // Input edge -> EDGE -> irq_o, then W1C
    bus(1'b1, 1, 64'h0, rd);
    bus(1'b1, 2, 64'h0, rd);
    ext_drv = 8'h00;
    steps(4);
    bus(1'b1, 4, 64'hFF, rd);
    bus(1'b1, 5, 64'h08, rd);
    steps(2);
`ifndef GPIO_DEBOUNCE_EN
    ext_drv[3] = 1'b1;
    step();
    chk("irq_e1", 64'(irq), 64'd0);
    step();
    chk("irq_e2", 64'(irq), 64'd0);
    step();
    chk("irq_e3", 64'(irq), 64'd1);
    bus(1'b0, 4, 64'h0, rd);
    chk("edge_pad3", rd, 64'h08);
    bus(1'b1, 4, 64'h08, rd);
    chk("irq_cleared", 64'(irq), 64'd0);
    // W1C landing on the same edge as a new pad-3 edge: the set wins
    ext_drv[3] = 1'b0;
    bus(1'b1, 4, 64'h08, rd);
    bus(1'b0, 4, 64'h0, rd);
    chk("edge_set_wins", rd, 64'h08);
    chk("irq_set_wins", 64'(irq), 64'd1);
`endif

    // Reset during the ack cycle of an OUT write
    bus(1'b1, 1, 64'hFF, rd);
    bus(1'b1, 2, 64'h00, rd);
    cs_pulses = 0;
    req = 1'b1; we = 1'b1; addr = 3'd2; wdata = 64'hFF;
    step();
    chk("ack_before_rst", 64'(ack), 64'd1);
    rst = 1'b1; req = 1'b0;
    step();
    rst = 1'b0;
    #0;
    chk("ack_after_rst", 64'(ack), 64'd0);
    steps(2);
    chk("no_cs_after_rst", 64'(cs_pulses), 64'd0);
    bus(1'b0, 2, 64'h0, rd);
    chk("out_after_rst", rd, 64'h0);

`ifdef GPIO_DEBOUNCE_EN
    ext_drv = 8'h00;
    steps(12);
    bus(1'b1, 4, 64'hFF, rd);
    bus(1'b1, 5, 64'h01, rd);
    // 3-cycle glitch is filtered
    ext_drv[0] = 1'b1;
    steps(3);
    ext_drv[0] = 1'b0;
    steps(10);
    bus(1'b0, 3, 64'h0, rd);
    chk("db_glitch_in", rd, 64'h0);
    bus(1'b0, 4, 64'h0, rd);
    chk("db_glitch_edge", rd, 64'h0);
    // Stable high: IN/EDGE follow after 2 + DB edges, irq one later
    ext_drv[0] = 1'b1;
    steps(6);
    chk("db_irq_e6", 64'(irq), 64'd0);
    step();
    chk("db_irq_e7", 64'(irq), 64'd1);
    bus(1'b0, 3, 64'h0, rd);
    chk("db_in_high", rd, 64'h01);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) == 0) ext_drv = N'($urandom);
      steps(int'($urandom_range(0, 3)));
      bus(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), {$urandom, $urandom}, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
